// File: rtl/mc_control.sv
// mc_control: multicycle main control unit (Moore FSM).
// Sequences each instruction through fetch, decode, execute, memory and
// writeback states. It drives the datapath enables, the mux selects and the
// 2-bit ALU-op code consumed by the ALU-control decoder.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   opcode[5:0]         IR[31:26], sampled in DECODE and MEMADDR only
//   memready            memory access completes this cycle
//   pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite   enables
//   iord, memtoreg, pcsource, alusrca, alusrcb, regdst           mux selects
//   aluop1, aluop0      00 add, 01 sub, 10 R-type
//   illegal             unsupported opcode seen in DECODE
//   state[3:0]          current state (debug)
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       memready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       irwrite,
    output logic [1:0] pcsource,
    output logic       aluop1,
    output logic       aluop0,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       regwrite,
    output logic       regdst,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StIExec    = 4'd10,
        StIWb      = 4'd11
    } state_t;

    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpAddi = 6'b001000;

    state_t     state_q, state_d;
    logic [1:0] aluop;

    // Next-state logic
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = memready ? StDecode : StFetch;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpR:        state_d = StRExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StIExec;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAddr:  state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  state_d = memready ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = memready ? StFetch : StMemWrite;
            StRExec:    state_d = StRWb;
            StRWb:      state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJump:     state_d = StFetch;
            StIExec:    state_d = StIWb;
            StIWb:      state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode. Reset gates the enables combinationally so nothing can
    // pulse while reset is high, including the instant it is asserted.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        pcsource    = 2'b00;
        aluop       = 2'b00;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            StFetch: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
            end
            StDecode: begin
                alusrcb = 2'b11;
                illegal = !(opcode inside {OpLw, OpSw, OpR, OpBeq, OpJ, OpAddi});
            end
            StMemAddr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRead: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            StMemWb: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            StMemWrite: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            StRExec: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            StRWb: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            StBranch: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            StJump: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            StIExec: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StIWb: begin
                regwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            irwrite     = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            regwrite    = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign aluop1 = aluop[1];
    assign aluop0 = aluop[0];
    assign state  = state_q;

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables, mux selects and the 2-bit ALU-op code (aluop1/aluop0) consumed by the ALU-control decoder. This block is the initiator side of the ALU-op interface; it sits between the instruction register's opcode field and the multicycle datapath.

## Interface

- No parameters.
- clk  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-high; forces state to FETCH
- opcode  in  6  IR[31:26], stable from DECODE onward
- memready  in  1  memory access complete this cycle
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  PC write if ALU zero
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = MDR
- irwrite  out  1  IR load
- pcsource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- aluop1, aluop0  out  1 each  00 = add, 01 = sub, 10 = R-type (decode funct)
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- regwrite  out  1  register file write
- regdst  out  1  0 = rt, 1 = rd
- illegal  out  1  unsupported opcode seen in DECODE
- state  out  4  current state (debug)

## Operation

- Moore FSM: one 4-bit state register; all outputs are combinational functions of state, plus memready where noted. Any output not listed for a state is 0.
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADDR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE
  - 6 REXEC, 7 RWB, 8 BRANCH, 9 JUMP, 10 IEXEC, 11 IWB
  - 12–15 are unused and go to FETCH next cycle.
- FETCH: memread=1, alusrcb=01, irwrite=memready, pcwrite=memready. Go to DECODE when memready=1, else hold.
- DECODE: alusrcb=11 (branch target precompute). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADDR
  - 000000 → REXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 (addi) → IEXEC
  - otherwise → FETCH with illegal=1
- MEMADDR: alusrca=1, alusrcb=10. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: memread=1, iord=1. Hold until memready=1, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Then FETCH.
- MEMWRITE: memwrite=1, iord=1, held high while waiting. Hold until memready=1, then FETCH.
- REXEC: alusrca=1, alusrcb=00, aluop=10. Then RWB.
- RWB: regwrite=1, regdst=1. Then FETCH.
- BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01. Then FETCH.
- JUMP: pcwrite=1, pcsource=10. Then FETCH.
- IEXEC: alusrca=1, alusrcb=10, aluop=00. Then IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. Then FETCH.
- Reset behaviour:
  - While reset=1, state=0 and pcwrite, pcwritecond, irwrite, memread, memwrite, regwrite and illegal are all forced to 0. Selects take their FETCH values.
  - Reset asserted mid-instruction aborts it immediately; no write enable may pulse on the reset edge.

## Timing

- State updates on the rising edge of clk. Reset acts asynchronously, independent of clk.
- Cycle counts with memready held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle memready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. Request outputs stay asserted and stable throughout the wait.
- memready is ignored in every other state.
- opcode is sampled only in DECODE and MEMADDR. Changes in other states have no effect.
- First FETCH after reset deasserts begins at the next rising edge. Outputs are valid in the same cycle as the state (Moore, zero latency).

## Test plan

- **Reset then lw, memready=1.** Reset pulse, then opcode=100011. State sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. Exactly one pcwrite, in cycle 0.
- **sw with memory stall.** opcode=101011, memready low for 3 cycles in MEMWRITE. State 5 lasts 4 cycles with memwrite=1 and iord=1 throughout. Then FETCH. regwrite never asserted.
- **R-type then beq.** R-type: states 0,1,6,7 with aluop=10 in state 6 and regdst=1 in state 7. beq: states 0,1,8 with aluop=01, pcwritecond=1 and pcsource=01.
- **Jump and addi.** j (000010): states 0,1,9 with pcwrite=1 and pcsource=10. addi (001000): states 0,1,10,11 with alusrcb=10 in state 10 and regwrite=1, regdst=0 in state 11.
- **Illegal opcode 111111.** illegal=1 for one cycle in DECODE, then FETCH. No regwrite, memwrite or pcwritecond at any point.
- **Reset asserted asynchronously mid-MEMWB.** state goes to 0 before the next clk edge and regwrite drops to 0 immediately. After reset release, normal fetch resumes.
